// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
// The entry struct is sized by FETCH_XLEN / FETCH_DATA_WIDTH; fetch_unit must be
// built with matching XLEN / DATA_WIDTH values.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN       = 32;
  localparam int unsigned FETCH_DATA_WIDTH = 32;

  // Byte distance between consecutive instruction words.
  localparam logic [FETCH_XLEN-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_DATA_WIDTH-1:0] inst;
    logic [FETCH_XLEN-1:0]       pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction SRAM read port, redirect request and decoder handshake.
// master = fetch_unit side, slave = memory/decoder/branch-unit side.
interface fetch_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  memEn;
  logic                  memR;
  logic [ADDR_WIDTH-1:0] memRAddr;
  logic [DATA_WIDTH-1:0] memData;
  logic                  redirect;
  logic [XLEN-1:0]       redirectPc;
  logic                  instValid;
  logic [DATA_WIDTH-1:0] inst;
  logic [XLEN-1:0]       instPc;
  logic                  instReady;

  modport master (
    output memEn, memR, memRAddr, instValid, inst, instPc,
    input  memData, redirect, redirectPc, instReady
  );

  modport slave (
    input  memEn, memR, memRAddr, instValid, inst, instPc,
    output memData, redirect, redirectPc, instReady
  );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: prefetch FIFO of fetch_entry_t. DEPTH must be a power of two so
// the pointers wrap naturally. Flush wins over push and pop in the same cycle;
// push into a full queue is accepted only together with a pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_q == {CNT_W{1'b0}});
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign do_pop_s  = pop && !empty && !flush;
  assign do_push_s = push && !flush && (!full || do_pop_s);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue state registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, one-word-per-cycle SRAM read issue, capture of the returning
// word into the prefetch queue and redirect/flush handling.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned-redirect trap to HALT).
// Issue uses a registered credit count (queued + in-flight), so instReady never
// reaches memR combinationally.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN        = FETCH_XLEN,
  parameter int unsigned     ADDR_WIDTH  = 10,
  parameter int unsigned     DATA_WIDTH  = FETCH_DATA_WIDTH,
  parameter int unsigned     QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = {XLEN{1'b0}}
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     fetchEn,
  fetch_if.master  bus,
  output logic     misaligned
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t          state_q, state_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       in_flight_pc_q, in_flight_pc_d;
  logic                  in_flight_q, in_flight_d;
  logic [XLEN-1:0]       redir_pc_s;
  logic                  redir_misaligned_s;
  logic                  issue_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  q_empty_s;
  logic                  q_full_s;
  logic [CNT_W-1:0]      q_count_s;
  logic [CNT_W-1:0]      credit_s;
  logic [DATA_WIDTH-1:0] mem_word_s;
  fetch_entry_t          push_entry_s;
  fetch_entry_t          head_s;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;

  assign redir_pc_s         = bus.redirectPc;
  assign redir_misaligned_s = bus.redirect && (bus.redirectPc[1:0] != 2'b00);
  assign misaligned         = misaligned_q;

  // Sticky flag: every redirect rewrites it from the target alignment.
  always_comb begin
    if (bus.redirect) begin
      misaligned_d = redir_misaligned_s;
    end else begin
      misaligned_d = misaligned_q;
    end
  end

  // Misaligned flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end
`else
  // Without the check, redirect targets are forced word aligned.
  assign redir_pc_s         = bus.redirectPc & {{(XLEN-2){1'b1}}, 2'b00};
  assign redir_misaligned_s = 1'b0;
  assign misaligned         = 1'b0;
`endif

  // Credit covers words already queued plus the one returning from the SRAM;
  // the full-queue term is a second guard in case the credit is ever disturbed.
  assign credit_s = q_count_s + CNT_W'(in_flight_q);
  assign issue_s  = (state_q == RUN) && !bus.redirect &&
                    (credit_s < CNT_W'(QUEUE_DEPTH)) && !q_full_s;

  assign bus.memR     = issue_s;
  assign bus.memEn    = issue_s;
  assign bus.memRAddr = pc_q[ADDR_WIDTH+1:2];

  assign mem_word_s   = bus.memData;
  assign push_s       = in_flight_q && !bus.redirect;
  assign push_entry_s = '{inst: mem_word_s, pc: in_flight_pc_q};
  assign pop_s        = !q_empty_s && bus.instReady;

  assign bus.instValid = !q_empty_s;
  assign bus.inst      = head_s.inst;
  assign bus.instPc    = head_s.pc;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (bus.redirect),
    .head      (head_s),
    .empty     (q_empty_s),
    .full      (q_full_s),
    .count     (q_count_s)
  );

  // FSM next state: misaligned redirect traps, aligned redirect leaves HALT.
  always_comb begin
    state_d = state_q;
    if (bus.redirect && redir_misaligned_s) begin
      state_d = HALT;
    end else if (bus.redirect && (state_q == HALT)) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetchEn) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (fetchEn) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // PC and in-flight tracking; redirect overrides issue and drops the returning word.
  always_comb begin
    pc_d           = pc_q;
    in_flight_d    = 1'b0;
    in_flight_pc_d = in_flight_pc_q;
    if (bus.redirect) begin
      pc_d        = redir_pc_s;
      in_flight_d = 1'b0;
    end else if (issue_s) begin
      pc_d           = pc_q + PC_INCR;
      in_flight_d    = 1'b1;
      in_flight_pc_d = pc_q;
    end else begin
      pc_d        = pc_q;
      in_flight_d = 1'b0;
    end
  end

  // Fetch control registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      in_flight_q    <= 1'b0;
      in_flight_pc_q <= {XLEN{1'b0}};
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      in_flight_q    <= in_flight_d;
      in_flight_pc_q <= in_flight_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench with a scoreboard. Stimulus pushes expected PCs
// into exp_q; the monitor pops and compares on every accepted decoder handshake.
// Memory model: word n holds the value n.
module tb_fetch_unit;

  logic clk;
  logic rst;
  logic fetchEn;
  logic misaligned;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  fetch_if #(.XLEN(32), .ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

  fetch_unit #(
    .XLEN        (32),
    .ADDR_WIDTH  (10),
    .DATA_WIDTH  (32),
    .QUEUE_DEPTH (4),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetchEn    (fetchEn),
    .bus        (bus),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM, 1-cycle read latency, word n = n.
  always @(posedge clk) begin
    if (bus.memEn && bus.memR) bus.memData <= 32'(bus.memRAddr);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // Scoreboard monitor: one comparison per accepted word.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && bus.instValid && bus.instReady && !bus.redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected: got pc %0h expected no word", bus.instPc);
      end else begin
        e = exp_q.pop_front();
        chk("mon_pc", 64'(bus.instPc), 64'(e));
        chk("mon_inst", 64'(bus.inst), 64'({22'd0, e[11:2]}));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_iss;
    int first_iss;
    int first_valid;
    bit found;

    rst = 1'b0;
    fetchEn = 1'b1;
    bus.instReady = 1'b0;
    bus.redirect = 1'b0;
    bus.redirectPc = 32'd0;
    #2 rst = 1'b1;
    #1;
    chk("rst_memR", 64'(bus.memR), 64'd0);
    chk("rst_memEn", 64'(bus.memEn), 64'd0);
    chk("rst_instValid", 64'(bus.instValid), 64'd0);
    chk("rst_misaligned", 64'(misaligned), 64'd0);

    // Fill with instReady low: exactly four reads, head holds word 0.
    step();
    rst = 1'b0;
    n_iss = 0;
    first_iss = -1;
    first_valid = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      #1;
      if (bus.memR) begin
        chk("fill_addr", 64'(bus.memRAddr), 64'(n_iss));
        if (first_iss < 0) first_iss = k;
        n_iss++;
      end
      if (bus.instValid && first_valid < 0) first_valid = k;
    end
    chk("fill_issue_count", 64'(n_iss), 64'd4);
    chk("issue_to_valid", 64'(first_valid - first_iss), 64'd2);
    chk("full_memR", 64'(bus.memR), 64'd0);
    chk("head_valid", 64'(bus.instValid), 64'd1);
    chk("head_inst", 64'(bus.inst), 64'd0);
    chk("head_pc", 64'(bus.instPc), 64'd0);

    // Raise instReady: issue resumes one cycle later, then one word per cycle.
    step();
    bus.instReady = 1'b1;
    push_exp(32'h0000_0000, 20);
    #1;
    chk("pop_cycle_memR", 64'(bus.memR), 64'd0);
    step();
    #1;
    chk("resume_memR", 64'(bus.memR), 64'd1);
    chk("resume_addr", 64'(bus.memRAddr), 64'd4);
    for (int k = 0; k < 10; k++) begin
      step();
      #1;
      chk("sustain_memR", 64'(bus.memR), 64'd1);
    end

    // Stall until full with a read in flight, then redirect to 0x40.
    step();
    bus.instReady = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (!bus.memR) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("wait_full", 64'(found), 64'd1);
    bus.redirect = 1'b1;
    bus.redirectPc = 32'h0000_0040;
    bus.instReady = 1'b1;
    exp_q.delete();
    push_exp(32'h0000_0040, 12);
    #1;
    chk("redir_no_issue", 64'(bus.memR), 64'd0);
    step();
    bus.redirect = 1'b0;
    #1;
    chk("redir_r1_valid", 64'(bus.instValid), 64'd0);
    chk("redir_r1_memR", 64'(bus.memR), 64'd1);
    chk("redir_r1_addr", 64'(bus.memRAddr), 64'h10);
    step();
    #1;
    chk("redir_r2_valid", 64'(bus.instValid), 64'd0);
    step();
    #1;
    chk("redir_r3_valid", 64'(bus.instValid), 64'd1);
    chk("redir_r3_pc", 64'(bus.instPc), 64'h40);
    chk("redir_r3_inst", 64'(bus.inst), 64'h10);
    for (int k = 0; k < 4; k++) step();

    // PC wrap at the top of the address space.
    step();
    bus.redirect = 1'b1;
    bus.redirectPc = 32'hFFFF_FFFC;
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFFC);
    push_exp(32'h0000_0000, 8);
    step();
    bus.redirect = 1'b0;
    #1;
    chk("wrap_addr_top", 64'(bus.memRAddr), 64'h3FF);
    step();
    #1;
    chk("wrap_addr_zero", 64'(bus.memRAddr), 64'h000);
    step();
    #1;
    chk("wrap_pc_top", 64'(bus.instPc), 64'hFFFF_FFFC);
    step();
    #1;
    chk("wrap_pc_zero", 64'(bus.instPc), 64'h0);
    chk("wrap_inst_zero", 64'(bus.inst), 64'h0);
    for (int k = 0; k < 3; k++) step();

    // Asynchronous reset pulse mid-cycle, then restart from RESET_PC.
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_memR", 64'(bus.memR), 64'd0);
    chk("arst_memEn", 64'(bus.memEn), 64'd0);
    chk("arst_instValid", 64'(bus.instValid), 64'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    push_exp(32'h0000_0000, 8);
    found = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      #1;
      if (bus.memR) begin
        found = 1'b1;
        break;
      end
    end
    chk("arst_restart", 64'(found), 64'd1);
    chk("arst_first_addr", 64'(bus.memRAddr), 64'd0);
    step();
    step();
    #1;
    chk("arst_first_valid", 64'(bus.instValid), 64'd1);
    chk("arst_first_pc", 64'(bus.instPc), 64'd0);

    // Redirect to an unaligned target.
    step();
    bus.redirect = 1'b1;
    bus.redirectPc = 32'h0000_0042;
    exp_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
    step();
    bus.redirect = 1'b0;
    #1;
    chk("mis_flag_set", 64'(misaligned), 64'd1);
    chk("mis_no_valid", 64'(bus.instValid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("mis_no_issue", 64'(bus.memR), 64'd0);
      step();
    end
    bus.redirect = 1'b1;
    bus.redirectPc = 32'h0000_0080;
    push_exp(32'h0000_0080, 8);
    step();
    bus.redirect = 1'b0;
    #1;
    chk("mis_flag_clear", 64'(misaligned), 64'd0);
    chk("mis_resume_memR", 64'(bus.memR), 64'd1);
    chk("mis_resume_addr", 64'(bus.memRAddr), 64'h20);
    step();
    step();
    #1;
    chk("mis_resume_pc", 64'(bus.instPc), 64'h80);
`else
    push_exp(32'h0000_0040, 8);
    step();
    bus.redirect = 1'b0;
    #1;
    chk("align_flag_zero", 64'(misaligned), 64'd0);
    chk("align_forced_addr", 64'(bus.memRAddr), 64'h10);
    step();
    step();
    #1;
    chk("align_forced_pc", 64'(bus.instPc), 64'h40);
`endif

    // fetchEn low stops issue once the FSM returns to IDLE; the queue drains.
    step();
    fetchEn = 1'b0;
    step();
    #1;
    chk("fetchen_off_memR", 64'(bus.memR), 64'd0);
    for (int k = 0; k < 6; k++) step();
    chk("drained_valid", 64'(bus.instValid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
